// File: rtl/esram_rd_arbiter.sv
// Round-robin, packet-atomic arbiter for the shared eSRAM read port.
// An in-order tag FIFO steers each returned beat back to the requester that issued it.
module esram_rd_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int AWIDTH       = 17,
    parameter int DWIDTH       = 520,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                              clk_datamover,
    input  logic                              rst_datamover_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*AWIDTH-1:0]         req_addr,
    input  logic [NUM_REQ-1:0]                req_last,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              esram_rden,
    output logic [AWIDTH-1:0]                 esram_rdaddress,
    input  logic                              esram_rd_valid,
    input  logic [DWIDTH-1:0]                 esram_rddata,
    output logic [NUM_REQ-1:0]                resp_valid,
    output logic [DWIDTH-1:0]                 resp_data,
    output logic [$clog2(MAX_INFLIGHT):0]     inflight_cnt,
    output logic                              err_spurious_rd
);

    localparam int CW = $clog2(MAX_INFLIGHT) + 1;
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       last_grant_q, last_grant_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic                rden_q, rden_d;
    logic [AWIDTH-1:0]   rdaddress_q, rdaddress_d;
    logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [DWIDTH-1:0]   resp_data_q, resp_data_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]       tag_mem_q [MAX_INFLIGHT];

    logic                credit_ok;
    logic                found;
    logic [IW-1:0]       winner;
    logic [IW-1:0]       grant_idx;
    logic                fire;
    logic                pop;
    logic [AWIDTH-1:0]   grant_addr;
    logic [NUM_REQ-1:0]  head_onehot;

    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    // Ready is derived only from state, valids and the registered count, never from itself.
    always_comb begin
        credit_ok    = (cnt_q < CW'(MAX_INFLIGHT));
        winner       = '0;
        found        = 1'b0;
        req_ready    = '0;
        grant_idx    = '0;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[rr_index(last_grant_q, k)]) begin
                winner = rr_index(last_grant_q, k);
                found  = 1'b1;
            end
        end
        case (state_q)
            IDLE: begin
                grant_idx = winner;
                if (found) req_ready[winner] = credit_ok;
            end
            BURST: begin
                grant_idx          = owner_q;
                req_ready[owner_q] = credit_ok;
            end
            default: begin
                grant_idx = winner;
            end
        endcase
        fire = |(req_valid & req_ready);
        if (fire) begin
            if (req_last[grant_idx]) begin
                state_d      = IDLE;
                last_grant_d = grant_idx;
            end else begin
                state_d = BURST;
                owner_d = grant_idx;
            end
        end
    end

    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IW'(i)) grant_addr = req_addr[i*AWIDTH +: AWIDTH];
        end
        pop         = esram_rd_valid && (cnt_q != '0);
        rden_d      = fire;
        rdaddress_d = fire ? grant_addr : rdaddress_q;
        wr_ptr_d    = wr_ptr_q + PW'(fire);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        case ({fire, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        head_onehot                      = '0;
        head_onehot[tag_mem_q[rd_ptr_q]] = 1'b1;
        resp_valid_d = pop ? head_onehot : '0;
        resp_data_d  = pop ? esram_rddata : resp_data_q;
        // A return with nothing outstanding is dropped but remembered until reset.
        err_d        = err_q | (esram_rd_valid && (cnt_q == '0));
    end

    always_ff @(posedge clk_datamover or negedge rst_datamover_n) begin
        if (!rst_datamover_n) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NUM_REQ - 1);
            owner_q      <= '0;
            rden_q       <= 1'b0;
            rdaddress_q  <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            rden_q       <= rden_d;
            rdaddress_q  <= rdaddress_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_datamover or negedge rst_datamover_n) begin
        if (!rst_datamover_n) begin
            for (int i = 0; i < MAX_INFLIGHT; i++) tag_mem_q[i] <= '0;
        end else if (fire) begin
            tag_mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    assign esram_rden      = rden_q;
    assign esram_rdaddress = rdaddress_q;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign inflight_cnt    = cnt_q;
    assign err_spurious_rd = err_q;

endmodule
